pcileech_sysctl: RTL and testbench
==================================

# pcileech_sysctl

Parametrised board system-control block: generates the stretched system reset, a 64-bit free-running tick counter, debounced button states with press and long-press events, and per-LED drive with mode selection and a power-on blink overlay. It sits directly under each board top module, between the raw button/LED pads and the `pcileech_com` / `pcileech_fifo` / `pcileech_pcie_a7` instances. It replaces the ad-hoc tick, reset and LED logic with one verified unit shared across boards.

## Interface
Parameters:
- PARAM_NUM_BTN, 2: number of buttons (1..4).
- PARAM_NUM_LED, 2: number of LEDs (1..4).
- PARAM_DEBOUNCE_CYC, 1000000: cycles a synced input must be stable before the debounced state changes (≥2).
- PARAM_LONGPRESS_CYC, 500000000: cycles held before btn_long fires (> PARAM_DEBOUNCE_CYC).
- PARAM_RST_HOLD_CYC, 64: sys_rst stretch after the reset source releases (≥1).
- PARAM_RST_BTN, 1: index of the button that forces sys_rst. A value ≥ PARAM_NUM_BTN disables this.
- PARAM_BLINK_BIT, 24: tickcount64 bit used for the power-on and slow blink. Fast blink uses bit PARAM_BLINK_BIT-3.
- PARAM_PWRON_BITS, 27: power-on overlay is active while tickcount64[63:PARAM_PWRON_BITS] == 0.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- btn_n  in  PARAM_NUM_BTN  raw active-low buttons, asynchronous to clk.
- btn_state  out  PARAM_NUM_BTN  debounced pressed state, 1 = pressed.
- btn_press  out  PARAM_NUM_BTN  1-cycle pulse on each debounced 0→1 transition.
- btn_long  out  PARAM_NUM_BTN  1-cycle pulse once per hold, when the hold reaches PARAM_LONGPRESS_CYC.
- sys_rst  out  1  stretched system reset, active-high.
- tickcount64  out  64  cycles since sys_rst last released.
- led_src  in  PARAM_NUM_LED  live status source per LED.
- led_mode  in  2*PARAM_NUM_LED  per-LED mode, bits [2i+1:2i]. 00 = src, 01 = ~src, 10 = slow blink, 11 = fast blink.
- led_pwron_en  in  PARAM_NUM_LED  enables the power-on overlay per LED.
- led  out  PARAM_NUM_LED  registered LED drive, active-high.

## Operation
- Reset values while rst=1, on the next clk edge:
  - btn_state, btn_press, btn_long = 0.
  - sys_rst = 1, tickcount64 = 0, led = 0.
  - All counters and synchronizers = 0 (synchronizers load "released").
- Input sync: 2-FF synchronizer per button on ~btn_n.
- Debounce, per button, counter `db`:
  - synced sample == btn_state → db cleared.
  - Otherwise db increments.
  - When db == PARAM_DEBOUNCE_CYC-1 and the sample still differs, btn_state toggles and db clears.
  - Any glitch shorter than PARAM_DEBOUNCE_CYC cycles never changes btn_state.
- btn_press = btn_state rising edge, registered.
- Long press, per button, counter `hold`:
  - Counts while btn_state=1 and saturates at PARAM_LONGPRESS_CYC.
  - btn_long pulses in the cycle hold transitions to PARAM_LONGPRESS_CYC.
  - Clears when btn_state=0. Exactly one pulse per hold.
- Reset FSM, states RESET → HOLD → RUN:
  - RESET: entered whenever rst=1. sys_rst=1.
  - HOLD: hcnt counts up. sys_rst=1. While btn_state[PARAM_RST_BTN]=1, hcnt is held at 0. Exits to RUN when hcnt == PARAM_RST_HOLD_CYC-1 and the button is released.
  - RUN: sys_rst=0. Goes to HOLD with hcnt=0 when the enabled reset button's btn_state=1.
- tickcount64 <= sys_rst ? 0 : tickcount64+1. Wraps modulo 2^64, with no special handling.
- LED, per LED i:
  - Base value by mode: src, ~src, tickcount64[PARAM_BLINK_BIT], or tickcount64[PARAM_BLINK_BIT-3].
  - led[i] <= base ^ (led_pwron_en[i] & tickcount64[PARAM_BLINK_BIT] & (tickcount64[63:PARAM_PWRON_BITS]==0)).
  - led = 0 while sys_rst=1.
- led_mode and led_src are sampled every cycle; a mode change takes effect on the next led update.

## Timing
- Button-to-btn_state latency: 2 sync cycles + PARAM_DEBOUNCE_CYC cycles from the first stable sample.
- btn_press: 1 cycle after btn_state rises.
- btn_long: PARAM_LONGPRESS_CYC cycles after btn_state rises.
- sys_rst after rst falls: remains 1 for exactly PARAM_RST_HOLD_CYC cycles, then 0.
- tickcount64: reads 0 in the first sys_rst=0 cycle, then increments by 1 each cycle.
- led: 1-cycle registered latency from led_src / led_mode / tickcount64.
- Boundary conditions:
  - rst asserted mid-debounce or mid-hold clears everything; no btn_press or btn_long is emitted.
  - A reset-button press during HOLD extends HOLD.
  - A reset-button release and rst asserted in the same cycle → RESET wins.
  - Simultaneous presses on several buttons are handled independently; each gets its own pulses.

## Test plan
Test configuration: DEBOUNCE=16, LONGPRESS=100, RST_HOLD=8, BLINK_BIT=4, PWRON_BITS=7.

1. rst high 5 cycles, then low → sys_rst=1 for 8 more cycles. tickcount64 = 0,1,2… from the first sys_rst=0 cycle. btn_state=0, led=0 throughout reset.
2. btn_n[0] low for 10 cycles, then high → btn_state, btn_press, btn_long all remain 0.
3. btn_n[0] held low for 200 cycles → btn_state[0] rises at cycle 18 (±1). btn_press[0] pulses once. btn_long[0] pulses once, 100 cycles after the btn_state rise. btn_long[0] does not repeat before release.
4. btn_n[1] (reset button) low for 40 cycles while in RUN:
   - sys_rst rises after debounce and stays high while the button is held.
   - After btn_state[1] falls, sys_rst stays high for 8 more cycles, then drops.
   - tickcount64 restarts at 0.
5. led_mode=00 with led_src toggling, led_pwron_en=0 → led follows led_src with 1-cycle delay.
   - mode=10 → led toggles every 16 cycles.
   - mode=11 → led toggles every 2 cycles.
   - With led_pwron_en=1 and mode=00 → XOR overlay active only while tickcount64 < 128.
6. rst pulsed during a 50-cycle button hold → no btn_long. The debounce cycle restarts from 0 after reset.

Source files
------------

// File: rtl/pcileech_sysctl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pcileech_sysctl: stretched system reset, 64-bit tick counter, debounced   |
// | buttons with press/long-press events, and per-LED drive with blink modes. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module pcileech_sysctl #(
  parameter int PARAM_NUM_BTN       = 2,
  parameter int PARAM_NUM_LED       = 2,
  parameter int PARAM_DEBOUNCE_CYC  = 1000000,
  parameter int PARAM_LONGPRESS_CYC = 500000000,
  parameter int PARAM_RST_HOLD_CYC  = 64,
  parameter int PARAM_RST_BTN       = 1,
  parameter int PARAM_BLINK_BIT     = 24,
  parameter int PARAM_PWRON_BITS    = 27
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PARAM_NUM_BTN-1:0]   btn_n,
  output logic [PARAM_NUM_BTN-1:0]   btn_state,
  output logic [PARAM_NUM_BTN-1:0]   btn_press,
  output logic [PARAM_NUM_BTN-1:0]   btn_long,
  output logic                       sys_rst,
  output logic [63:0]                tickcount64,
  input  logic [PARAM_NUM_LED-1:0]   led_src,
  input  logic [2*PARAM_NUM_LED-1:0] led_mode,
  input  logic [PARAM_NUM_LED-1:0]   led_pwron_en,
  output logic [PARAM_NUM_LED-1:0]   led
);

  localparam int DB_W   = $clog2(PARAM_DEBOUNCE_CYC);
  localparam int HOLD_W = $clog2(PARAM_LONGPRESS_CYC + 1);
  localparam int HC_W   = (PARAM_RST_HOLD_CYC > 1) ? $clog2(PARAM_RST_HOLD_CYC) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(PARAM_DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(PARAM_LONGPRESS_CYC);
  localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(PARAM_LONGPRESS_CYC - 1);
  localparam logic [HC_W-1:0]   HC_LAST   = HC_W'(PARAM_RST_HOLD_CYC - 1);

  genvar gi;

  generate
    for (gi = 0; gi < PARAM_NUM_BTN; gi++) begin : g_btn
      logic              sync1_q, sync2_q, state_q, state_prev_q, press_q, long_q;
      logic [DB_W-1:0]   db_q;
      logic [HOLD_W-1:0] hold_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q      <= 1'b0;
          sync2_q      <= 1'b0;
          state_q      <= 1'b0;
          state_prev_q <= 1'b0;
          press_q      <= 1'b0;
          long_q       <= 1'b0;
          db_q         <= '0;
          hold_q       <= '0;
        end else begin
          sync1_q      <= ~btn_n[gi];
          sync2_q      <= sync1_q;
          if (sync2_q == state_q) begin
            db_q <= '0;
          end else if (db_q == DB_LAST) begin
            state_q <= ~state_q;
            db_q    <= '0;
          end else begin
            db_q <= db_q + 1'b1;
          end
          state_prev_q <= state_q;
          press_q      <= state_q & ~state_prev_q;
          // hold saturates, so HOLD_PRE is crossed exactly once per hold
          if (!state_q) begin
            hold_q <= '0;
          end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + 1'b1;
          end
          long_q <= state_q && (hold_q == HOLD_PRE);
        end
      end

      assign btn_state[gi] = state_q;
      assign btn_press[gi] = press_q;
      assign btn_long[gi]  = long_q;
    end
  endgenerate

  logic rst_btn;
  generate
    if (PARAM_RST_BTN < PARAM_NUM_BTN) begin : g_rst_btn
      assign rst_btn = btn_state[PARAM_RST_BTN];
    end else begin : g_no_rst_btn
      assign rst_btn = 1'b0;
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [HC_W-1:0] hcnt_q, hcnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // RESET behaves as the first HOLD cycle so the stretch counts from rst release
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      ST_RESET, ST_HOLD: begin
        if (rst_btn) begin
          state_d = ST_HOLD;
          hcnt_d  = '0;
        end else if (hcnt_q == HC_LAST) begin
          state_d = ST_RUN;
          hcnt_d  = '0;
        end else begin
          state_d = ST_HOLD;
          hcnt_d  = hcnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (rst_btn) begin
          state_d = ST_HOLD;
          hcnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_RESET;
        hcnt_d  = '0;
      end
    endcase
  end

  assign sys_rst = (state_q != ST_RUN);

  logic [63:0] tick_q;
  always_ff @(posedge clk) begin
    if (rst || sys_rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 64'd1;
    end
  end
  assign tickcount64 = tick_q;

  logic                     pwron_blink;
  logic [PARAM_NUM_LED-1:0] led_d, led_q;

  assign pwron_blink = tick_q[PARAM_BLINK_BIT] & (tick_q[63:PARAM_PWRON_BITS] == '0);

  generate
    for (gi = 0; gi < PARAM_NUM_LED; gi++) begin : g_led
      logic base;
      always_comb begin
        base = 1'b0;
        case (led_mode[2*gi +: 2])
          2'b00:   base = led_src[gi];
          2'b01:   base = ~led_src[gi];
          2'b10:   base = tick_q[PARAM_BLINK_BIT];
          default: base = tick_q[PARAM_BLINK_BIT-3];
        endcase
      end
      assign led_d[gi] = base ^ (led_pwron_en[gi] & pwron_blink);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || sys_rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end
  assign led = led_q;

endmodule
`default_nettype wire

// File: tb/tb_pcileech_sysctl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pcileech_sysctl: directed bench for pcileech_sysctl (small parameters). |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_pcileech_sysctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  btn_n;
  logic [1:0]  btn_state, btn_press, btn_long;
  logic        sys_rst;
  logic [63:0] tickcount64;
  logic [1:0]  led_src;
  logic [3:0]  led_mode;
  logic [1:0]  led_pwron_en;
  logic [1:0]  led;

  always #5 clk = ~clk;

  pcileech_sysctl #(
    .PARAM_NUM_BTN      (2),
    .PARAM_NUM_LED      (2),
    .PARAM_DEBOUNCE_CYC (16),
    .PARAM_LONGPRESS_CYC(100),
    .PARAM_RST_HOLD_CYC (8),
    .PARAM_RST_BTN      (1),
    .PARAM_BLINK_BIT    (4),
    .PARAM_PWRON_BITS   (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .btn_state   (btn_state),
    .btn_press   (btn_press),
    .btn_long    (btn_long),
    .sys_rst     (sys_rst),
    .tickcount64 (tickcount64),
    .led_src     (led_src),
    .led_mode    (led_mode),
    .led_pwron_en(led_pwron_en),
    .led         (led)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_tick = '0;

  typedef struct {
    logic [3:0] mode;
    logic [1:0] src;
    logic [1:0] pwr;
    logic [1:0] exp_led;
  } led_vec_t;

  led_vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    exp_tick = exp_tick + 64'd1;
  endtask

  function automatic logic [1:0] led_model(input logic [3:0] mode, input logic [1:0] src,
                                           input logic [1:0] pwr, input logic [63:0] t);
    logic [1:0] r;
    logic       b;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      case (mode[2*i +: 2])
        2'b00:   b = src[i];
        2'b01:   b = ~src[i];
        2'b10:   b = t[4];
        default: b = t[1];
      endcase
      r[i] = b ^ (pwr[i] & t[4] & (t < 64'd128));
    end
    return r;
  endfunction

  initial begin
    int bad, n_rise0, n_rise1, n_press0, n_press1, n_long, n_sr, n_fall, n_srlow;
    int press_cnt, long_cnt, other;
    logic [63:0] tick_at;
    logic [1:0]  e;

    vecs[0] = '{4'b0000, 2'b01, 2'b00, 2'b01};
    vecs[1] = '{4'b0000, 2'b10, 2'b00, 2'b10};
    vecs[2] = '{4'b0000, 2'b11, 2'b00, 2'b11};
    vecs[3] = '{4'b0101, 2'b01, 2'b00, 2'b10};
    vecs[4] = '{4'b0001, 2'b00, 2'b00, 2'b01};
    vecs[5] = '{4'b0100, 2'b11, 2'b00, 2'b01};
    vecs[6] = '{4'b0000, 2'b00, 2'b00, 2'b00};

    // 1: reset and stretch
    rst = 1'b1; btn_n = 2'b11; led_src = 2'b11; led_mode = 4'b0000; led_pwron_en = 2'b00;
    repeat (5) step();
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_tick", tickcount64, 0);
    chk("rst_btn_state", btn_state, 0);
    chk("rst_led", led, 0);
    chk("rst_press_long", {btn_press, btn_long}, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (sys_rst !== 1'b1 || led !== 2'b00 || btn_state !== 2'b00) bad++;
      step();
    end
    chk("rst_stretch", bad, 0);
    chk("sys_rst_release", sys_rst, 0);
    chk("tick_first", tickcount64, 0);
    exp_tick = '0;
    step();
    chk("tick_second", tickcount64, 1);
    step();
    chk("tick_third", tickcount64, 2);
    led_src = 2'b00;

    // 2: short glitch
    btn_n = 2'b10;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) btn_n = 2'b11;
      step();
      if (btn_state !== 2'b00 || btn_press !== 2'b00 || btn_long !== 2'b00) bad++;
    end
    chk("glitch_ignored", bad, 0);

    // 3: long hold on button 0
    btn_n = 2'b10;
    n_rise0 = -1; n_press0 = -1; n_long = -1; press_cnt = 0; long_cnt = 0; other = 0;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (btn_state[0] && n_rise0 < 0) n_rise0 = n;
      if (btn_press[0]) begin press_cnt++; n_press0 = n; end
      if (btn_long[0])  begin long_cnt++;  n_long = n; end
      if (sys_rst || btn_state[1] || btn_press[1] || btn_long[1]) other++;
    end
    chk("hold_rise_cycle", n_rise0, 18);
    chk("hold_press_count", press_cnt, 1);
    chk("hold_press_cycle", n_press0, 19);
    chk("hold_long_count", long_cnt, 1);
    chk("hold_long_cycle", n_long, 118);
    chk("hold_no_side_effect", other, 0);
    btn_n = 2'b11;
    repeat (25) step();
    chk("hold_released", btn_state, 0);

    // 4: both buttons, button 1 forces sys_rst
    btn_n = 2'b00;
    n_rise0 = -1; n_rise1 = -1; n_press0 = -1; n_press1 = -1; n_sr = -1; long_cnt = 0; bad = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (btn_state[0] && n_rise0 < 0) n_rise0 = n;
      if (btn_state[1] && n_rise1 < 0) n_rise1 = n;
      if (btn_press[0]) n_press0 = n;
      if (btn_press[1]) n_press1 = n;
      if (sys_rst && n_sr < 0) n_sr = n;
      if (n_sr > 0 && !sys_rst) bad++;
      if (btn_long !== 2'b00) long_cnt++;
    end
    chk("dual_rise0", n_rise0, 18);
    chk("dual_rise1", n_rise1, 18);
    chk("dual_press0", n_press0, 19);
    chk("dual_press1", n_press1, 19);
    chk("rstbtn_sys_rst_rise", n_sr, 19);
    btn_n = 2'b11;
    n_fall = -1; n_srlow = -1; tick_at = '1;
    for (int m = 1; m <= 40; m++) begin
      step();
      if (!btn_state[1] && n_fall < 0) n_fall = m;
      if (!sys_rst && n_srlow < 0) n_srlow = m;
      if (m == 26) begin tick_at = tickcount64; exp_tick = '0; end
      if (btn_long !== 2'b00) long_cnt++;
    end
    chk("rstbtn_fall", n_fall, 18);
    chk("rstbtn_sys_rst_held", bad, 0);
    chk("rstbtn_sys_rst_drop", n_srlow, 26);
    chk("rstbtn_tick_restart", tick_at, 0);
    chk("rstbtn_tick_count", tickcount64, exp_tick);
    chk("dual_no_long", long_cnt, 0);

    // 5: LED vectors, power-on overlay, blink modes
    for (int v = 0; v < 7; v++) begin
      led_mode = vecs[v].mode; led_src = vecs[v].src; led_pwron_en = vecs[v].pwr;
      step();
      chk($sformatf("led_vec%0d", v), led, vecs[v].exp_led);
    end
    led_mode = 4'b0000; led_src = 2'b00; led_pwron_en = 2'b11;
    bad = 0;
    for (int i = 0; i < 170; i++) begin
      e = led_model(led_mode, led_src, led_pwron_en, exp_tick);
      step();
      if (led !== e) bad++;
    end
    chk("led_pwron_overlay", bad, 0);
    led_pwron_en = 2'b00; led_mode = 4'b1010;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      e = led_model(led_mode, led_src, led_pwron_en, exp_tick);
      step();
      if (led !== e) bad++;
    end
    chk("led_slow_blink", bad, 0);
    led_mode = 4'b1111;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      e = led_model(led_mode, led_src, led_pwron_en, exp_tick);
      step();
      if (led !== e) bad++;
    end
    chk("led_fast_blink", bad, 0);
    led_mode = 4'b1110;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      e = led_model(led_mode, led_src, led_pwron_en, exp_tick);
      step();
      if (led !== e) bad++;
    end
    chk("led_mixed_blink", bad, 0);

    // 6: rst pulsed during a button hold
    led_mode = 4'b0000;
    btn_n = 2'b10;
    press_cnt = 0; long_cnt = 0; bad = 0; n_press0 = -1;
    for (int n = 1; n <= 140; n++) begin
      step();
      if (btn_press[0]) begin press_cnt++; n_press0 = n; end
      if (btn_long !== 2'b00) long_cnt++;
      if ((n == 31 || n == 32) && (btn_state !== 2'b00 || sys_rst !== 1'b1 || tickcount64 !== 64'd0)) bad++;
      if (n == 39) chk("mid_rst_sys_rst_hold", sys_rst, 1);
      if (n == 40) chk("mid_rst_sys_rst_drop", sys_rst, 0);
      if (n == 49) chk("mid_rst_db_restart_pre", btn_state[0], 0);
      if (n == 50) chk("mid_rst_db_restart_rise", btn_state[0], 1);
      if (n == 30) rst = 1'b1;
      if (n == 32) rst = 1'b0;
    end
    chk("mid_rst_cleared", bad, 0);
    chk("mid_rst_press_count", press_cnt, 2);
    chk("mid_rst_press_cycle", n_press0, 51);
    chk("mid_rst_no_long", long_cnt, 0);
    btn_n = 2'b11;
    repeat (25) step();
    chk("mid_rst_released", btn_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
